// File: rtl/cos_req_sequencer.sv
// Initiator for the cosine engine start/done handshake: request in, start pulse, result out.
// Optional engine timeout abort is compiled in when COS_SEQ_TIMEOUT_EN is defined.
module cos_req_sequencer #(
    parameter int DATA_W         = 16,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_angle,
    output logic              core_start,
    output logic              core_hold,
    input  logic              core_done,
    output logic [DATA_W-1:0] core_x,
    input  logic [DATA_W-1:0] core_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_err,
    output logic              busy,
    output logic [15:0]       op_count
);

    // state       | meaning
    // S_IDLE      | waiting for a request while the engine reports done
    // S_START     | one-cycle start pulse, operand already on core_x
    // S_WAIT_BUSY | waiting for the engine to drop done
    // S_WAIT_DONE | waiting for the engine to raise done again
    // S_RESP      | result held until the consumer accepts it
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    logic [2:0]        r_state;
    logic [3:0]        r_setup_cnt;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_result;
    logic              r_valid;
    logic              r_start;
    logic [15:0]       r_ops;

    logic w_waiting;
    logic w_accept;
    logic w_handshake;
    logic w_done_rise;
    logic w_expire;

    assign w_waiting   = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    assign w_accept    = (r_state == S_IDLE) && in_valid && core_done;
    assign w_handshake = (r_state == S_RESP) && r_valid && out_ready;
    assign w_done_rise = (r_state == S_WAIT_DONE) && core_done;

`ifdef COS_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    // Expiry is flagged on the last counted wait cycle so RESP starts exactly TIMEOUT_CYCLES in.
    assign w_expire = w_waiting && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign out_err  = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else if (r_state == S_START) begin
            r_to_cnt <= '0;
        end else if (w_waiting) begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (w_done_rise)
                r_err <= 1'b0;
            else if (w_expire)
                r_err <= 1'b1;
        end else if (w_handshake) begin
            r_err <= 1'b0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_expire         = 1'b0;
    assign out_err          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_setup_cnt <= '0;
            r_x         <= '0;
            r_result    <= '0;
            r_valid     <= 1'b0;
            r_start     <= 1'b0;
            r_ops       <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x     <= in_angle;
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_setup_cnt <= 4'(SETUP_CYCLES);
                    r_state     <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    if (r_setup_cnt != 4'd0)
                        r_setup_cnt <= r_setup_cnt - 4'd1;
                    if (w_done_rise) begin
                        r_result    <= core_result;
                        r_valid     <= 1'b1;
                        r_setup_cnt <= '0;
                        r_state     <= S_RESP;
                    end else if (w_expire) begin
                        r_result    <= '0;
                        r_valid     <= 1'b1;
                        r_setup_cnt <= '0;
                        r_state     <= S_RESP;
                    end else if ((r_state == S_WAIT_BUSY) && !core_done) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_RESP: begin
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        r_ops   <= r_ops + 16'd1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE) && core_done;
    assign busy       = (r_state != S_IDLE);
    assign core_hold  = w_waiting && (r_setup_cnt != 4'd0);
    assign core_start = r_start;
    assign core_x     = r_x;
    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign op_count   = r_ops;

endmodule

// File: tb/tb_cos_req_sequencer.sv
// Self-checking bench for cos_req_sequencer with an inline engine model and randomized traffic.
// The timeout scenario is included when COS_SEQ_TIMEOUT_EN is defined.
module tb_cos_req_sequencer;

    localparam int DW    = 16;
    localparam int SETUP = 2;
    localparam int TMO   = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_angle;
    logic          core_start;
    logic          core_hold;
    logic          core_done;
    logic [DW-1:0] core_x;
    logic [DW-1:0] core_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_err;
    logic          busy;
    logic [15:0]   op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ops  = 0;
    int start_cnt = 0;
    int hold_cnt  = 0;

    cos_req_sequencer #(
        .DATA_W(DW),
        .SETUP_CYCLES(SETUP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_angle(in_angle),
        .core_start(core_start),
        .core_hold(core_hold),
        .core_done(core_done),
        .core_x(core_x),
        .core_result(core_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_err(out_err),
        .busy(busy),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Passive pulse/level counters; scenarios compare deltas.
    always @(posedge clk) begin
        if (core_start === 1'b1) start_cnt <= start_cnt + 1;
        if (core_hold === 1'b1)  hold_cnt  <= hold_cnt + 1;
    end

    // Engine returns angle ^ 0x7FFF; done is low on phases d..d+b-1 after the start phase.
    task automatic run_txn(input logic [15:0] angle, input int d, input int b,
                           input int stall, input bit early_rdy, output int acc_wait);
        logic [15:0] exp_res;
        int k, kv, s0, h0, exp_hold;
        bit x_bad, stall_bad;
        exp_res   = angle ^ 16'h7FFF;
        exp_hold  = (SETUP < d + b) ? SETUP : d + b;
        x_bad     = 1'b0;
        stall_bad = 1'b0;
        in_valid  = 1'b1;
        in_angle  = angle;
        out_ready = early_rdy;
        acc_wait  = 0;
        while (in_ready !== 1'b1 && acc_wait < 50) begin
            @(posedge clk); #1;
            acc_wait++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        s0 = start_cnt;
        h0 = hold_cnt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_angle = 16'($urandom);
        n_checks++;
        if (core_start !== 1'b1 || core_x !== angle || busy !== 1'b1 || core_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL start_phase: start=%b x=%h busy=%b hold=%b required 1 %h 1 0",
                     core_start, core_x, busy, core_hold, angle);
        end
        k  = 0;
        kv = -1;
        while (kv < 0 && k < 200) begin
            core_done   = !(k >= d && k < d + b);
            core_result = (k == d + b) ? exp_res : 16'($urandom);
            if (core_x !== angle) x_bad = 1'b1;
            @(posedge clk); #1;
            k++;
            if (out_valid === 1'b1) kv = k;
        end
        core_done   = 1'b1;
        core_result = 16'($urandom);
        n_checks++;
        if (kv != d + b + 1) begin
            n_fail++;
            $display("FAIL resp_latency: out_valid after %0d cycles required %0d", kv, d + b + 1);
        end
        n_checks++;
        if (out_result !== exp_res || out_err !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_value: result=%h err=%b in_ready=%b required %h 0 0",
                     out_result, out_err, in_ready, exp_res);
        end
        if (stall > 0) out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            core_result = 16'($urandom);
            if (out_valid !== 1'b1 || out_result !== exp_res || in_ready !== 1'b0) stall_bad = 1'b1;
            if (core_x !== angle) x_bad = 1'b1;
        end
        n_checks++;
        if (stall_bad) begin
            n_fail++;
            $display("FAIL resp_stall: output not held (valid=%b result=%h) required 1 %h",
                     out_valid, out_result, exp_res);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_ops++;
        n_checks++;
        if (out_valid !== 1'b0 || op_count !== 16'(exp_ops) || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake: valid=%b op_count=%0d busy=%b in_ready=%b required 0 %0d 0 1",
                     out_valid, op_count, busy, in_ready, exp_ops);
        end
        n_checks++;
        if (start_cnt - s0 != 1 || hold_cnt - h0 != exp_hold || x_bad) begin
            n_fail++;
            $display("FAIL pulses: starts=%0d hold_cycles=%0d x_unstable=%b required 1 %0d 0",
                     start_cnt - s0, hold_cnt - h0, x_bad, exp_hold);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (core_x !== 0 || out_result !== 0 || out_valid !== 0 || out_err !== 0 ||
            core_start !== 0 || core_hold !== 0 || op_count !== 0 || busy !== 0) begin
            n_fail++;
            $display("FAIL reset_values: x=%h res=%h v=%b err=%b st=%b hold=%b ops=%0d busy=%b required all 0",
                     core_x, out_result, out_valid, out_err, core_start, core_hold, op_count, busy);
        end
        rst = 1'b0;
        exp_ops = 0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int w;
        run_txn(16'h0000, 1, 6, 0, 1'b0, w);
        n_checks++;
        if (out_result !== 16'h7FFF || op_count !== 16'd1) begin
            n_fail++;
            $display("FAIL basic: result=%h op_count=%0d required 7fff 1", out_result, op_count);
        end
    endtask

    task automatic test_busy_engine();
        int s0, w;
        bit bad;
        bad      = 1'b0;
        s0       = start_cnt;
        core_done = 1'b0;
        in_valid = 1'b1;
        in_angle = 16'h0ABC;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || start_cnt != s0) begin
            n_fail++;
            $display("FAIL busy_engine: ready_or_busy_seen=%b starts=%0d required 0 0", bad, start_cnt - s0);
        end
        core_done = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL done_rise_ready: in_ready=%b required 1", in_ready);
        end
        run_txn(16'h0ABC, 1, 3, 0, 1'b0, w);
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL done_rise_accept: waited %0d cycles required 0", w);
        end
    endtask

    task automatic test_resp_stall();
        int w;
        run_txn(16'($urandom), 1, 4, 10, 1'b0, w);
    endtask

    task automatic test_reset_mid();
        bit bad;
        bad      = 1'b0;
        in_valid = 1'b1;
        in_angle = 16'h4321;
        @(posedge clk); #1;
        in_valid = 1'b0;
        core_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy !== 1'b1 || core_x !== 16'h4321) begin
            n_fail++;
            $display("FAIL mid_setup: busy=%b x=%h required 1 4321", busy, core_x);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (core_x !== 0 || out_result !== 0 || out_valid !== 0 || out_err !== 0 ||
            core_start !== 0 || core_hold !== 0 || op_count !== 0 || busy !== 0) begin
            n_fail++;
            $display("FAIL async_reset: x=%h res=%h v=%b err=%b st=%b hold=%b ops=%0d busy=%b required all 0",
                     core_x, out_result, out_valid, out_err, core_start, core_hold, op_count, busy);
        end
        exp_ops = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        core_done   = 1'b1;
        core_result = 16'hBEEF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_discard: response or activity seen after reset, required none");
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] angles [3];
        int w;
        angles[0] = 16'h1000;
        angles[1] = 16'h2000;
        angles[2] = 16'h3000;
        for (int i = 0; i < 3; i++) begin
            run_txn(angles[i], 1, 2 + i, 0, 1'b1, w);
            if (i > 0) begin
                n_checks++;
                if (w != 0) begin
                    n_fail++;
                    $display("FAIL b2b_accept: request %0d waited %0d cycles required 0", i, w);
                end
            end
        end
        n_checks++;
        if (op_count !== 16'd3) begin
            n_fail++;
            $display("FAIL b2b_count: op_count=%0d required 3", op_count);
        end
    endtask

    task automatic test_random();
        int d, b, st, w;
        bit er;
        for (int t = 0; t < 20; t++) begin
            d  = $urandom_range(0, 3);
            b  = (d == 0) ? $urandom_range(2, 8) : $urandom_range(1, 8);
            st = $urandom_range(0, 4);
            er = 1'($urandom_range(0, 1));
            run_txn(16'($urandom), d, b, st, er, w);
        end
    endtask

`ifdef COS_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int kv;
        in_valid = 1'b1;
        in_angle = 16'($urandom);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        core_done = 1'b0;
        kv = -1;
        for (int k = 1; k <= 30 && kv < 0; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) kv = k;
        end
        n_checks++;
        if (kv != TMO + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: out_valid after %0d cycles required %0d", kv, TMO + 1);
        end
        n_checks++;
        if (out_err !== 1'b1 || out_result !== 16'h0000 || core_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_value: err=%b result=%h hold=%b required 1 0000 0",
                     out_err, out_result, core_hold);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_ops++;
        n_checks++;
        if (out_valid !== 1'b0 || op_count !== 16'(exp_ops)) begin
            n_fail++;
            $display("FAIL timeout_handshake: valid=%b op_count=%0d required 0 %0d",
                     out_valid, op_count, exp_ops);
        end
        core_done = 1'b1;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_angle    = '0;
        core_done   = 1'b1;
        core_result = '0;
        out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_busy_engine();
        test_resp_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef COS_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
